// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: assembles big-endian words and writes them to instruction memory.
// Optional trailing checksum byte is enabled with `define CHECKSUM_EN.
module instruction_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_run
);

    localparam int          CW  = ADDR_WIDTH + 1;
    localparam int unsigned CAP = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTES = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef CHECKSUM_EN
        , S_CHECK = 3'd6
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]            idx_q, idx_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  accept_s;
    logic                  last_word_s;

`ifdef CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s    = rx_valid & rx_ready_q;
    // Compare in CW bits so a full-capacity load ends on the top address without wrapping.
    assign last_word_s = (({1'b0, mem_addr_q} + CW'(1)) == count_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        idx_d       = idx_q;
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_COUNT;
                end else begin
                    state_d = state_q;
                end
            end
            S_COUNT: begin
                if (accept_s) begin
                    if ((rx_data == 8'd0) || ({24'd0, rx_data} > CAP)) begin
                        state_d = S_ERR;
                    end else begin
                        count_d    = CW'(rx_data);
                        mem_addr_d = '0;
                        idx_d      = 2'd0;
                        state_d    = S_BYTES;
                    end
`ifdef CHECKSUM_EN
                    csum_d = csum_step(8'd0, rx_data);
`endif
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_BYTES: begin
                if (accept_s) begin
                    mem_wdata_d = {mem_wdata_q[23:0], rx_data};
`ifdef CHECKSUM_EN
                    csum_d      = csum_step(csum_q, rx_data);
`endif
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = S_BYTES;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
`ifdef CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    state_d    = S_BYTES;
                end
            end
`ifdef CHECKSUM_EN
            S_CHECK: begin
                if (accept_s) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d = S_CHECK;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = 1'b0;
        busy_d     = 1'b0;
        case (state_d)
            S_COUNT, S_BYTES: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: busy_d = 1'b1;
`ifdef CHECKSUM_EN
            S_CHECK: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
`endif
            default: begin
                rx_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
        mem_we_d = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERR);
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            idx_q       <= 2'd0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            idx_q       <= idx_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_run   = done_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven loads against a stream-level model,
// plus hand sequences for idle bytes, mid-load reset and (with CHECKSUM_EN) a bad checksum.
module tb_instruction_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_run;

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = -1;
    bit done_prev = 1'b0;
    logic [AW+31:0] wr_q[$];
    int             we_cyc_q[$];

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            we_cyc_q.push_back(cyc);
        end
        if (done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (done === 1'b1);
    end

    typedef struct {
        logic [7:0] cnt;
        bit         fixed;
        int         gap;
        bit         exp_ok;
        int         mid_start;
    } vec_t;

    vec_t tbl[8];
    logic [31:0] fixed_w[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        bit acc = 1'b0;
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        if (pulse_start) start = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        chk("byte_accept", {63'd0, acc}, 64'd1);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_load(input string name, input logic [7:0] cnt, input bit fixed, input int gap,
                            input bit exp_ok, input int mid_start, input bit bad_ck);
        logic [7:0]     s[$];
        logic [AW+31:0] exp_w[$];
        logic [31:0]    w;
        logic [7:0]     x;
        bit             model_ok;
        int             n;
        int             g;
        int             lat;
        model_ok = (int'(cnt) >= 1) && (int'(cnt) <= (1 << AW));
        s.push_back(cnt);
        if (model_ok) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = fixed ? fixed_w[i % 2] : $urandom();
                for (int k = 3; k >= 0; k--) s.push_back(w[k*8 +: 8]);
                exp_w.push_back({AW'(i), w});
            end
        end
        x = 8'd0;
        foreach (s[i]) x = x ^ s[i];
`ifdef CHECKSUM_EN
        if (model_ok) s.push_back(bad_ck ? 8'hFF : x);
`endif
        model_ok = model_ok && !bad_ck;
        chk({name, " table_vs_model"}, {63'd0, model_ok}, {63'd0, exp_ok});

        wr_q.delete();
        we_cyc_q.delete();
        done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (s[i]) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            send_byte(s[i], g, (i == mid_start));
        end
        rx_valid = 1'b0;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);

        chk({name, " done"},    {63'd0, done},    {63'd0, exp_ok});
        chk({name, " error"},   {63'd0, error},   {63'd0, !exp_ok});
        chk({name, " cpu_run"}, {63'd0, cpu_run}, {63'd0, exp_ok});
        chk({name, " busy"},    {63'd0, busy},    64'd0);
        chk({name, " n_writes"}, 64'(wr_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            chk({name, " write"}, 64'(wr_q[i]), 64'(exp_w[i]));

        if (gap == 0 && exp_ok && mid_start < 0 && we_cyc_q.size() > 0) begin
`ifdef CHECKSUM_EN
            lat = 2;
`else
            lat = 1;
`endif
            chk({name, " done_latency"}, 64'(done_cyc - we_cyc_q[we_cyc_q.size()-1]), 64'(lat));
            for (int i = 1; i < we_cyc_q.size(); i++)
                chk({name, " word_spacing"}, 64'(we_cyc_q[i] - we_cyc_q[i-1]), 64'd5);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " rx_ready"},  {63'd0, rx_ready},  64'd0);
        chk({name, " mem_we"},    {63'd0, mem_we},    64'd0);
        chk({name, " busy"},      {63'd0, busy},      64'd0);
        chk({name, " done"},      {63'd0, done},      64'd0);
        chk({name, " error"},     {63'd0, error},     64'd0);
        chk({name, " cpu_run"},   {63'd0, cpu_run},   64'd0);
        chk({name, " mem_addr"},  64'(mem_addr),      64'd0);
        chk({name, " mem_wdata"}, 64'(mem_wdata),     64'd0);
    endtask

    initial begin
        fixed_w[0] = 32'h28020005;
        fixed_w[1] = 32'h2803000C;
        //         cnt     fixed  gap  ok    mid_start
        tbl[0] = '{8'h02, 1'b1,  0,   1'b1, -1};
        tbl[1] = '{8'h02, 1'b1,  3,   1'b1, -1};
        tbl[2] = '{8'h00, 1'b0,  0,   1'b0, -1};
        tbl[3] = '{8'h41, 1'b0,  0,   1'b0, -1};
        tbl[4] = '{8'h40, 1'b0,  0,   1'b1, -1};
        tbl[5] = '{8'h01, 1'b0, -1,   1'b1, -1};
        tbl[6] = '{8'h05, 1'b0, -1,   1'b1,  6};
        tbl[7] = '{8'hFF, 1'b0,  0,   1'b0, -1};

        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Bytes offered in IDLE are not consumed.
        wr_q.delete();
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_rx_ready", {63'd0, rx_ready}, 64'd0);
        end
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_no_write", 64'(wr_q.size()), 64'd0);
        rx_valid = 1'b0;

        for (int i = 0; i < 8; i++)
            run_load($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fixed, tbl[i].gap,
                     tbl[i].exp_ok, tbl[i].mid_start, 1'b0);

        // Reset after the 6th byte of a 2-word load, then a clean reload.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h28, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h28, 0, 1'b0);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk_reset_outputs("midload_reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_load("after_reset", 8'h02, 1'b1, 0, 1'b1, -1, 1'b0);

`ifdef CHECKSUM_EN
        run_load("bad_checksum", 8'h02, 1'b1, 0, 1'b0, -1, 1'b1);
        run_load("good_after_bad", 8'h02, 1'b1, 0, 1'b1, -1, 1'b0);
`endif

        // Bytes offered in DONE are not consumed and the result holds.
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("done_holds", {63'd0, done}, 64'd1);
        rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
